// File: rtl/iat_pkg.sv
// Shared definitions for the IAT pulse link (generator and filter agree on MIN_GAP / N).
package iat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } iat_state_e;

  localparam int unsigned IAT_MIN_GAP_DEF = 2;
  localparam int unsigned IAT_CNT_W_DEF   = 4;
  localparam int unsigned IAT_DROP_CNT_W  = 8;

  // Width needed to hold a gap count of 0..min_gap.
  function automatic int unsigned iat_gap_cnt_w(input int unsigned min_gap);
    return (min_gap < 1) ? 1 : $clog2(min_gap + 1);
  endfunction

endpackage

// File: rtl/iat_gap_timer.sv
// Counts low cycles since the last issued pulse; eligible once MIN_GAP have elapsed.
module iat_gap_timer
  import iat_pkg::*;
#(
  parameter int unsigned MIN_GAP = IAT_MIN_GAP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic eligible
);

  localparam int unsigned     GW   = iat_gap_cnt_w(MIN_GAP);
  localparam logic [GW-1:0]   GMAX = GW'(MIN_GAP);

  logic [GW-1:0] r_gap_cnt;
  logic [GW-1:0] w_gap_next;
  logic          r_eligible;

  always_comb begin
    w_gap_next = r_gap_cnt;
    if (restart) begin
      w_gap_next = '0;
    end else if (r_gap_cnt < GMAX) begin
      w_gap_next = r_gap_cnt + GW'(1);
    end
  end

  // Eligibility is registered from the next count so it lines up with r_gap_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt  <= GMAX;
      r_eligible <= 1'b1;
    end else begin
      r_gap_cnt  <= w_gap_next;
      r_eligible <= (w_gap_next == GMAX);
    end
  end

  assign eligible = r_eligible;

endmodule

// File: rtl/iat_pulse_gen.sv
// IAT pulse generator: queues requests and emits one-cycle pulses spaced by MIN_GAP low cycles.
// Optional drop_cnt output enabled by defining IAT_GEN_DROP_CNT_EN.
module iat_pulse_gen
  import iat_pkg::*;
#(
  parameter int unsigned MIN_GAP = IAT_MIN_GAP_DEF,
  parameter int unsigned CNT_W   = IAT_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req,
  output logic             out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             drop
`ifdef IAT_GEN_DROP_CNT_EN
  ,
  output logic [IAT_DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam logic [CNT_W-1:0] PMAX = '1;

  iat_state_e       r_state;
  iat_state_e       w_state_next;
  logic [CNT_W-1:0] r_pending;
  logic [CNT_W-1:0] w_pending_next;
  logic             r_out;
  logic             r_busy;
  logic             r_drop;
  logic             w_eligible;
  logic             w_demand;
  logic             w_issue;
  logic             w_drop;

  assign w_demand = req | (r_pending != '0);
  assign w_issue  = en & w_eligible & w_demand;

  iat_gap_timer #(
    .MIN_GAP (MIN_GAP)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (w_issue),
    .eligible (w_eligible)
  );

  // A request arriving with an issue is consumed directly; saturation only drops when no issue.
  always_comb begin
    w_pending_next = r_pending;
    w_drop         = 1'b0;
    unique case ({req, w_issue})
      2'b10: begin
        if (r_pending == PMAX) begin
          w_drop = 1'b1;
        end else begin
          w_pending_next = r_pending + CNT_W'(1);
        end
      end
      2'b01:   w_pending_next = r_pending - CNT_W'(1);
      default: w_pending_next = r_pending;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_issue) w_state_next = PULSE;
      end
      PULSE: w_state_next = GAP;
      GAP: begin
        if (w_issue) begin
          w_state_next = PULSE;
        end else if (w_eligible && !w_demand) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= 1'b0;
      r_pending <= '0;
      r_drop    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_out     <= w_issue;
      r_pending <= w_pending_next;
      r_drop    <= w_drop;
      r_busy    <= (w_pending_next != '0) || (w_state_next != IDLE);
    end
  end

  assign out     = r_out;
  assign pending = r_pending;
  assign drop    = r_drop;
  assign busy    = r_busy;

`ifdef IAT_GEN_DROP_CNT_EN
  logic [IAT_DROP_CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + IAT_DROP_CNT_W'(1);
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_iat_pulse_gen.sv
// Self-checking bench for iat_pulse_gen: directed scenarios plus random traffic vs a cycle-level model.
module tb_iat_pulse_gen;

  localparam int unsigned MIN_GAP = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int          PMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b0;
  logic             req = 1'b0;
  logic             out;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             drop;
`ifdef IAT_GEN_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif

  always #5 clk = ~clk;

  iat_pulse_gen #(
    .MIN_GAP (MIN_GAP),
    .CNT_W   (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .out     (out),
    .busy    (busy),
    .pending (pending),
    .drop    (drop)
`ifdef IAT_GEN_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue length, time of last pulse, cycle counter.
  int m_t      = 0;
  int m_pend   = 0;
  int m_last   = 0;
  bit m_has_last = 1'b0;
  bit m_out    = 1'b0;
  bit m_drop   = 1'b0;
  int m_dcnt   = 0;
  int d_last   = 0;
  bit d_has_out = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", tag, got, exp, m_t, $time);
    end
  endtask

  task automatic compare_all();
    bit exp_busy;
    exp_busy = (m_pend != 0) || (m_has_last && (m_t - m_last <= int'(MIN_GAP)));
    check_eq("out",     int'(out),     int'(m_out));
    check_eq("pending", int'(pending), m_pend);
    check_eq("busy",    int'(busy),    int'(exp_busy));
    check_eq("drop",    int'(drop),    int'(m_drop));
`ifdef IAT_GEN_DROP_CNT_EN
    check_eq("drop_cnt", int'(drop_cnt), m_dcnt);
`endif
    if (out === 1'b1) begin
      if (d_has_out) check_eq("spacing", int'((m_t - d_last) > int'(MIN_GAP)), 1);
      d_last    = m_t;
      d_has_out = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare at the next falling edge.
  task automatic step(input bit r, input bit e);
    bit elig;
    bit issue;
    bit dn;
    req  = r;
    en   = e;
    elig  = !m_has_last || (m_t - m_last >= int'(MIN_GAP));
    issue = e && elig && (r || (m_pend > 0));
    dn    = r && !issue && (m_pend == PMAX);
    if (!dn) m_pend = m_pend + int'(r) - int'(issue);
    if (dn && (m_dcnt < 255)) m_dcnt++;
    m_t++;
    if (issue) begin
      m_last     = m_t;
      m_has_last = 1'b1;
    end
    m_out  = issue;
    m_drop = dn;
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    en    = 1'b0;
    #1;
    m_pend     = 0;
    m_has_last = 1'b0;
    m_out      = 1'b0;
    m_drop     = 1'b0;
    m_dcnt     = 0;
    d_has_out  = 1'b0;
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();

    // Single request: one pulse with one-cycle latency.
    repeat (4) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b1);

    // Four-cycle burst drains at MIN_GAP+1 spacing.
    repeat (4) step(1'b1, 1'b1);
    repeat (12) step(1'b0, 1'b1);

    // Held request saturates the small queue and drops.
    repeat (8) step(1'b1, 1'b1);
    repeat (15) step(1'b0, 1'b1);

    // Hold with en=0, then release.
    repeat (2) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1);

    // en dropped right after an issue: pulse completes, no new issue.
    step(1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0);
    repeat (14) step(1'b0, 1'b1);

    // Reset in the middle of a train, then a fresh request.
    repeat (3) step(1'b1, 1'b1);
    do_reset();
    step(1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1);

    // Random traffic with varying burst density, en gating and occasional resets.
    for (int blk = 0; blk < 60; blk++) begin
      int p_req;
      int p_en;
      p_req = int'($urandom_range(90, 5));
      p_en  = (blk % 4 == 3) ? 40 : 95;
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(999) < 3) do_reset();
        step(bit'(int'($urandom_range(99)) < p_req), bit'(int'($urandom_range(99)) < p_en));
      end
    end
    repeat (20) step(1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
